// File: rtl/spi_master_write.sv
// Serialises valid/ready register-write requests into 3-wire SPI frames:
// CS low, ADDR then DATA MSB first, SDATA changing on SCLK fall, DONE as CS returns high.
module spi_master_write #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              VALID,
    output logic              READY,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              CS,
    output logic              SCLK,
    output logic              SDATA
);

    localparam int W     = ADDR_W + DATA_W;
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = $clog2(W + CS_GAP + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(W - 1);
    localparam logic [IDX_W-1:0] GAP_LAST = IDX_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     shreg_q, shreg_d;
    logic             cs_q, cs_d;
    logic             sclk_q, sclk_d;
    logic             sdata_q, sdata_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;

    assign tick = (cnt_q == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        sdata_d = sdata_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        // Half-period timer: reload on expiry, so CLK_DIV=1 ticks every cycle without wrapping.
        if (state_q != S_IDLE) begin
            cnt_d = tick ? CNT_MAX : cnt_q - CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (VALID && ready_q) begin
                    state_d = S_SETUP;
                    shreg_d = {ADDR, DATA};
                    sdata_d = ADDR[ADDR_W-1];
                    cs_d    = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_MAX;
                    idx_d   = '0;
                end
            end
            S_SETUP: begin
                if (tick) begin
                    state_d = S_SHIFT;
                    sclk_d  = 1'b1;
                end
            end
            S_SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        // Final fall keeps the last bit on SDATA through HOLD.
                        if (idx_q == BIT_LAST) begin
                            state_d = S_HOLD;
                        end else begin
                            shreg_d = {shreg_q[W-2:0], 1'b0};
                            sdata_d = shreg_q[W-2];
                            idx_d   = idx_q + IDX_W'(1);
                        end
                    end else begin
                        sclk_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    state_d = S_GAP;
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    idx_d   = '0;
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (idx_q == GAP_LAST) begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign READY = ready_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign CS    = cs_q;
    assign SCLK  = sclk_q;
    assign SDATA = sdata_q;

endmodule

// File: tb/tb_spi_master_write.sv
// Directed bench for spi_master_write: an SPI slave/register model decodes frames from
// the pins and measures CS/SCLK timing, checked against hand-computed values.
module tb_spi_master_write;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       VALID = 1'b0;
    logic [7:0] ADDR = '0;
    logic [7:0] DATA = '0;
    logic       READY, BUSY, DONE, CS, SCLK, SDATA;

    logic       VALID_b = 1'b0;
    logic [7:0] ADDR_b = '0;
    logic [7:0] DATA_b = '0;
    logic       READY_b, BUSY_b, DONE_b, CS_b, SCLK_b, SDATA_b;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    spi_master_write #(.ADDR_W(8), .DATA_W(8), .CLK_DIV(2), .CS_GAP(2)) dut (
        .CLK(CLK), .RST(RST), .VALID(VALID), .READY(READY), .ADDR(ADDR), .DATA(DATA),
        .BUSY(BUSY), .DONE(DONE), .CS(CS), .SCLK(SCLK), .SDATA(SDATA)
    );

    spi_master_write #(.ADDR_W(8), .DATA_W(8), .CLK_DIV(1), .CS_GAP(2)) dut_b (
        .CLK(CLK), .RST(RST), .VALID(VALID_b), .READY(READY_b), .ADDR(ADDR_b), .DATA(DATA_b),
        .BUSY(BUSY_b), .DONE(DONE_b), .CS(CS_b), .SCLK(SCLK_b), .SDATA(SDATA_b)
    );

    // Slave + register model for dut, sampled 2ns after each rising edge.
    logic [7:0]  regs [256];
    logic        mon_en = 1'b0;
    logic        cs_p = 1'b1, sclk_p = 1'b0;
    logic [15:0] shf = '0, last_frame = '0;
    int rises = 0, last_rises = 0, cslow = 0, last_cslow = 0;
    int chigh = 0, last_chigh = 0, gap_cnt = 0, last_gap = 0;
    int frames = 0, done_cnt = 0, bad_edges = 0;
    logic gap_on = 1'b0, done_at_rise = 1'b0;

    initial for (int i = 0; i < 256; i++) regs[i] = 8'h00;

    always @(posedge CLK) begin
        #2;
        if (mon_en) begin
            if (!CS && cs_p) begin
                last_chigh = chigh;
                rises = 0;
                cslow = 0;
                shf = '0;
            end
            if (!CS && SCLK && !sclk_p) begin
                rises++;
                shf = {shf[14:0], SDATA};
            end
            if (CS && cs_p && (SCLK !== sclk_p)) bad_edges++;
            if (DONE) done_cnt++;
            if (!CS) cslow++; else chigh++;
            if (gap_on) begin
                if (READY) begin gap_on = 1'b0; last_gap = gap_cnt; end
                else gap_cnt++;
            end
            if (CS && !cs_p) begin
                frames++;
                last_frame = shf;
                last_rises = rises;
                last_cslow = cslow;
                done_at_rise = DONE;
                if (rises == 16) regs[shf[15:8]] = shf[7:0];
                chigh = 1;
                gap_on = 1'b1;
                gap_cnt = 1;
            end
        end
        cs_p = CS;
        sclk_p = SCLK;
    end

    // Lighter monitor for the CLK_DIV=1 instance.
    logic        sclkb_p = 1'b0;
    logic [15:0] shf_b = '0;
    int rises_b = 0, cslow_b = 0, done_b = 0, per_b = 0, last_rise_cyc = 0, cyc_b = 0;

    always @(posedge CLK) begin
        #2;
        if (mon_en) begin
            if (!CS_b && SCLK_b && !sclkb_p) begin
                rises_b++;
                shf_b = {shf_b[14:0], SDATA_b};
                if (last_rise_cyc > 0) per_b = cyc_b - last_rise_cyc;
                last_rise_cyc = cyc_b;
            end
            if (!CS_b) cslow_b++;
            if (DONE_b) done_b++;
        end
        cyc_b++;
        sclkb_p = SCLK_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic accept(input logic [7:0] a, input logic [7:0] d, input bit keep);
        int n = 0;
        while (READY !== 1'b1 && n < 200) begin @(negedge CLK); n++; end
        check("accept_ready", READY, 1);
        VALID = 1'b1; ADDR = a; DATA = d;
        @(negedge CLK);
        if (!keep) VALID = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames < target && n < 300) begin @(negedge CLK); n++; end
        check("frame_timeout", frames, target);
    endtask

    initial begin
        int f0, d0, n, rdy_seen;

        // 1: reset
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        mon_en = 1'b1;
        check("rst_cs", CS, 1);
        check("rst_sclk", SCLK, 0);
        check("rst_sdata", SDATA, 0);
        check("rst_ready", READY, 1);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);

        // 2: single frame 0x01/0xA5, CS low (2*16+1)*2 = 66 cycles
        accept(8'h01, 8'hA5, 1'b0);
        check("acc_ready", READY, 0);
        check("acc_busy", BUSY, 1);
        check("acc_cs", CS, 0);
        check("acc_sdata_msb", SDATA, 0);
        wait_frames(1);
        check("f1_cslow", last_cslow, 66);
        check("f1_rises", last_rises, 16);
        check("f1_bits", last_frame, 16'h01A5);
        check("f1_done_at_cs_rise", done_at_rise, 1);
        check("f1_done_cnt", done_cnt, 1);
        check("f1_reg01", regs[8'h01], 8'hA5);
        n = 0;
        while (READY !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
        check("f1_gap_to_ready", last_gap, 4);
        check("f1_busy_idle", BUSY, 0);

        // 3: VALID held across two requests; READY comes CS_GAP*CLK_DIV=4 after CS rise,
        // and the second accept one cycle later, so CS is high 5 cycles between frames
        accept(8'h00, 8'h3C, 1'b1);
        ADDR = 8'h01; DATA = 8'hC3;
        n = 0;
        while (READY !== 1'b1 && n < 200) begin @(negedge CLK); n++; end
        @(negedge CLK);
        VALID = 1'b0;
        check("f3_second_accept_cs", CS, 0);
        wait_frames(3);
        check("f3_gap_to_ready", last_gap, 4);
        check("f3_cs_high_between", last_chigh, 5);
        check("f3_reg00", regs[8'h00], 8'h3C);
        check("f3_reg01", regs[8'h01], 8'hC3);
        check("f3_done_cnt", done_cnt, 3);

        // 4: inputs churn during the frame with VALID high
        f0 = frames;
        accept(8'h55, 8'hAA, 1'b1);
        n = 0;
        rdy_seen = 0;
        while (CS !== 1'b1 && n < 100) begin
            ADDR = 8'($urandom);
            DATA = 8'($urandom);
            if (READY) rdy_seen++;
            @(negedge CLK);
            n++;
        end
        VALID = 1'b0;
        repeat (20) @(negedge CLK);
        check("f4_no_ready_mid_frame", rdy_seen, 0);
        check("f4_one_frame", frames, f0 + 1);
        check("f4_bits", last_frame, 16'h55AA);
        check("f4_reg55", regs[8'h55], 8'hAA);

        // 5: reset after the 5th SCLK rise aborts the frame
        d0 = done_cnt;
        accept(8'h12, 8'h34, 1'b0);
        n = 0;
        while (rises < 5 && n < 100) begin @(negedge CLK); n++; end
        check("f5_reach_rise5", rises, 5);
        RST = 1'b1;
        @(negedge CLK);
        check("f5_abort_cs", CS, 1);
        check("f5_abort_sclk", SCLK, 0);
        check("f5_abort_busy", BUSY, 0);
        check("f5_abort_done", DONE, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (60) @(negedge CLK);
        check("f5_rises_frozen", last_rises, 5);
        check("f5_no_edges_cs_high", bad_edges, 0);
        check("f5_no_done", done_cnt, d0);
        check("f5_reg12_untouched", regs[8'h12], 8'h00);
        check("f5_ready_after", READY, 1);

        // 6: CLK_DIV=1, frame 0xFF/0x00, CS low 33 cycles, SCLK period 2
        VALID_b = 1'b1; ADDR_b = 8'hFF; DATA_b = 8'h00;
        @(negedge CLK);
        VALID_b = 1'b0;
        check("b_acc_cs", CS_b, 0);
        check("b_acc_sdata_msb", SDATA_b, 1);
        n = 0;
        while (done_b < 1 && n < 100) begin @(negedge CLK); n++; end
        repeat (5) @(negedge CLK);
        check("b_cslow", cslow_b, 33);
        check("b_rises", rises_b, 16);
        check("b_bits", shf_b, 16'hFF00);
        check("b_period", per_b, 2);
        check("b_done_cnt", done_b, 1);
        check("b_ready", READY_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
